c17_bist_ctrl: RTL and testbench
================================

Name: c17_bist_ctrl

Overview:
Built-in self-test sequencer for the c17 NAND2 benchmark datapath. It drives exhaustive 5-bit test patterns onto the c17 primary inputs and samples the two outputs after a programmable hold time. Each response is checked against an internal golden c17 model and compacted into a MISR signature. The block sits beside the c17 instance and is started and read by the gate-sizing characterisation harness.

Parameters:
NPAT, 32, number of patterns applied, 1..32; patterns 0..NPAT-1 are applied in ascending order.
HOLD, 1, cycles each pattern is held before its response is sampled; must be >= 1.
SIG_W, 16, MISR width; must be >= 2.
SIG_POLY, 16'h100B, MISR feedback polynomial (x^16+x^12+x^3+x+1).
SIG_SEED, 16'h0000, MISR value loaded on start.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin or restart a test run; sampled in IDLE and DONE only.
abort  in  1  cancel the run in progress.
tp_out  out  5  pattern {N1,N2,N3,N6,N7}; tp_out[4]=N1 and tp_out[0]=N7.
resp  in  2  DUT response {N22,N23}; resp[1]=N22.
busy  out  1  high while in RUN.
done  out  1  level; high in DONE.
pass  out  1  valid while done; high when fail_cnt==0.
fail_cnt  out  6  number of mismatching patterns.
first_fail  out  5  index of the first mismatching pattern; 0 if there is none.
signature  out  SIG_W  MISR contents.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. tp_out, busy, done, pass, fail_cnt, first_fail = 0. signature=SIG_SEED. rst overrides start and abort in every state.
- States:
  - IDLE: start=1 -> RUN. On that edge: pat=0, hold_cnt=0, fail_cnt=0, first_fail=0, signature=SIG_SEED, busy=1.
  - RUN: tp_out=pat (registered). Each cycle, hold_cnt increments. At hold_cnt==HOLD-1 the sample edge occurs:
    - resp is compared with gold(pat).
    - MISR update: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? SIG_POLY : 0) ^ {0, resp}.
    - On mismatch: fail_cnt+1. If fail_cnt was 0, first_fail<=pat.
    - If pat==NPAT-1: go to DONE, busy<=0, done<=1, pass<=(final fail_cnt==0). Otherwise pat+1 and hold_cnt<=0.
  - DONE: done, pass, fail_cnt, first_fail, signature and tp_out all hold their values. start=1 -> RUN with the same clearing as in IDLE, and done<=0 on that edge.
- Golden model, bitwise on pat:
  - N10=~(N1&N3), N11=~(N3&N6), N16=~(N2&N11), N19=~(N11&N7).
  - gold = {~(N10&N16), ~(N16&N19)}.
- Latency: for a start sampled at edge 0, busy=1 for NPAT*HOLD cycles. The last sample edge is at NPAT*HOLD, and done is visible from that edge.
- Sample point: the response is sampled at the final edge of the hold window. The DUT therefore has HOLD cycles to settle after tp_out changes.
- start=1 while in RUN is ignored.
- abort=1 in RUN -> IDLE on the next edge, with busy=0 and done=0. fail_cnt, first_fail and signature keep partial values; they are not valid. tp_out holds its value. abort has no effect in IDLE or DONE.
- abort and start high together in RUN: abort wins.
- start held high continuously: a new run starts every time the block enters DONE. done is high for exactly one cycle per run.
- fail_cnt cannot exceed 32, so it does not wrap.

Test Plan:
- Reset check: assert rst for 2 cycles with start=1 -> all outputs 0, signature=0, state IDLE, no run started.
- Good DUT, HOLD=1, NPAT=32, start pulse at edge 0:
  - tp_out steps 0..31 on consecutive cycles; busy high for 32 cycles; done=1 after edge 32.
  - pass=1, fail_cnt=0, first_fail=0.
  - signature equals the bench MISR reference model. Spot checks: gold(0)=2'b00, gold(31)=2'b10.
- resp[1] stuck-at-0 (N22), other bit from the true DUT -> fail_cnt=18, first_fail=8, pass=0 at done.
- HOLD=3 with a DUT output delay of 2 cycles:
  - each tp_out value is held 3 cycles; done after edge 96; pass=1.
  - With HOLD=1 and the same delayed DUT, pass=0.
- Abort: start at edge 0, abort at edge 10 -> busy=0 and done=0 after edge 10. A new start then completes normally with pass=1 and fail_cnt=0.
- Restart from DONE: after pass=0, pulse start with a good DUT -> done clears on the start edge, and fail_cnt and first_fail clear. The final result is pass=1 with fail_cnt=0.

Source files
------------

// File: rtl/c17_bist_ctrl.sv
// -----------------------------------------------------------------------------
// c17_bist_ctrl
//
// Built-in self-test sequencer for the c17 NAND2 benchmark. Patterns
// 0..NPAT-1 are driven onto the c17 primary inputs in ascending order. Each
// pattern is held for HOLD cycles, and the response is sampled on the last
// edge of that window. Each sampled response is compared against an internal
// golden c17 model and folded into a MISR signature.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin or restart a run (sampled in IDLE and DONE only)
//   abort      cancel a run in progress (RUN only; wins over start)
//   tp_out     test pattern {N1,N2,N3,N6,N7}
//   resp       c17 response {N22,N23}
//   busy       high while a run is in progress
//   done       high while in DONE
//   pass       valid with done; high when no pattern mismatched
//   fail_cnt   number of mismatching patterns
//   first_fail index of the first mismatching pattern (0 if none)
//   signature  MISR contents
// -----------------------------------------------------------------------------
module c17_bist_ctrl #(
    parameter int               NPAT     = 32,
    parameter int               HOLD     = 1,
    parameter int               SIG_W    = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(16'h100B),
    parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [4:0]       tp_out,
    input  logic [1:0]       resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [5:0]       fail_cnt,
    output logic [4:0]       first_fail,
    output logic [SIG_W-1:0] signature
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int             HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
    localparam logic [4:0]     PAT_LAST  = 5'(NPAT - 1);

    logic [1:0]       state;
    logic [HCW-1:0]   hold_cnt;
    logic             sample;
    logic             mismatch;
    logic [5:0]       fail_next;
    logic [SIG_W-1:0] sig_next;

    // Golden c17 netlist, evaluated on the pattern currently applied.
    function automatic logic [1:0] c17_gold(input logic [4:0] p);
        logic n1, n2, n3, n6, n7;
        logic n10, n11, n16, n19;
        {n1, n2, n3, n6, n7} = p;
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // so no latch is inferred.
    always_comb begin
        sample    = (hold_cnt == HOLD_LAST);
        mismatch  = (resp != c17_gold(tp_out));
        fail_next = fail_cnt + {5'd0, mismatch};
        // MISR: shift left, fold the MSB back through the polynomial, and
        // inject the raw response at the bottom.
        sig_next  = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? SIG_POLY : '0)
                  ^ SIG_W'(resp);
    end

    // tp_out doubles as the pattern index register, which is why abort leaves
    // it holding the last applied pattern.
    // NOTE: sequential state uses non-blocking assignments, so every branch
    // below reads the pre-edge value of each register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            tp_out     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= '0;
            signature  <= SIG_SEED;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        hold_cnt   <= '0;
                        tp_out     <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                        signature  <= SIG_SEED;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (sample) begin
                        signature <= sig_next;
                        fail_cnt  <= fail_next;
                        hold_cnt  <= '0;
                        if (mismatch && (fail_cnt == 6'd0)) begin
                            first_fail <= tp_out;
                        end
                        if (tp_out == PAT_LAST) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (fail_next == 6'd0);
                        end else begin
                            tp_out <= tp_out + 5'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_c17_bist_ctrl
//
// Self-checking bench for c17_bist_ctrl. It uses two instances: one with
// HOLD=1 and one with HOLD=3. The c17 response is produced by a bench-side
// model that can be good, N22 stuck-at-0, randomly corrupted per pattern, or
// delayed by two cycles. Expected run results come from a reference model that
// walks the pattern list with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_c17_bist_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, abort1, start3, abort3;
    logic [4:0]  tp1, tp3;
    logic [1:0]  resp1, resp3;
    logic        busy1, done1, pass1, busy3, done3, pass3;
    logic [5:0]  fail1, fail3;
    logic [4:0]  first1, first3;
    logic [15:0] sig1, sig3;

    int          n_vec = 0;
    int          n_bad = 0;

    // Response source for the HOLD=1 instance:
    // 0 = good, 1 = N22 stuck-at-0, 2 = random error mask, 3 = 2-cycle delay.
    int          mode1 = 0;
    logic [1:0]  emask [32];
    logic [1:0]  d1_1, d2_1, d1_3, d2_3;

    int          e_fail, e_first, e_sig;

    c17_bist_ctrl #(.NPAT(32), .HOLD(1)) u_h1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .tp_out(tp1), .resp(resp1), .busy(busy1), .done(done1),
        .pass(pass1), .fail_cnt(fail1), .first_fail(first1),
        .signature(sig1)
    );

    c17_bist_ctrl #(.NPAT(32), .HOLD(3)) u_h3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .tp_out(tp3), .resp(resp3), .busy(busy3), .done(done3),
        .pass(pass3), .fail_cnt(fail3), .first_fail(first3),
        .signature(sig3)
    );

    // c17 outputs in sum-of-products form:
    // N22 = N1.N3 + N2.~(N3.N6), N23 = ~(N3.N6).(N2 + N7).
    function automatic logic [1:0] gold(input logic [4:0] p);
        logic n1, n2, n3, n6, n7;
        {n1, n2, n3, n6, n7} = p;
        return {(n1 & n3) | (n2 & ~(n3 & n6)), ~(n3 & n6) & (n2 | n7)};
    endfunction

    function automatic logic [1:0] applied(input int m, input int p);
        logic [1:0] g;
        g = gold(5'(p));
        case (m)
            1:       return g & 2'b01;
            2:       return g ^ emask[p];
            default: return g;
        endcase
    endfunction

    always_comb resp1 = (mode1 == 3) ? d2_1 : applied(mode1, int'(tp1));
    assign resp3 = d2_3;

    always @(posedge clk) begin
        d1_1 <= gold(tp1);
        d2_1 <= d1_1;
        d1_3 <= gold(tp3);
        d2_3 <= d1_3;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result of a full run with response source m.
    task automatic model(input int m);
        int r;
        e_fail  = 0;
        e_first = 0;
        e_sig   = 0;
        for (int p = 0; p < 32; p++) begin
            r = int'(applied(m, p));
            if (r != int'(gold(5'(p)))) begin
                if (e_fail == 0) e_first = p;
                e_fail++;
            end
            e_sig = ((e_sig * 2) % 65536) ^ ((e_sig >= 32768) ? 'h100B : 0) ^ r;
        end
    endtask

    task automatic run1(input int m, input int rand_start);
        mode1 = m;
        model(m);
        start1 = 1'b1;
        step();                        // edge 0
        start1 = 1'b0;
        check("h1_busy_on", busy1, 1);
        check("h1_done_clr", done1, 0);
        check("h1_fail_clr", fail1, 0);
        check("h1_first_clr", first1, 0);
        for (int p = 0; p < 32; p++) begin
            check("h1_tp_step", tp1, p);
            check("h1_busy_run", busy1, 1);
            // start pulses during RUN must be ignored
            start1 = (rand_start != 0 && p < 31) ? 1'($urandom % 2) : 1'b0;
            step();
        end
        start1 = 1'b0;                 // now just after edge 32
        check("h1_done", done1, 1);
        check("h1_busy_off", busy1, 0);
        if (m == 3) begin
            check("h1_delay_pass", pass1, 0);
        end else begin
            check("h1_pass", pass1, (e_fail == 0) ? 1 : 0);
            check("h1_fail_cnt", fail1, e_fail);
            check("h1_first_fail", first1, e_first);
            check("h1_signature", sig1, e_sig);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b1;
        start3 = 1'b1;
        abort1 = 1'b0;
        abort3 = 1'b0;
        for (int i = 0; i < 32; i++) emask[i] = 2'b00;

        // Reset dominates start.
        step();
        step();
        check("rst_tp", tp1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_fail", fail1, 0);
        check("rst_first", first1, 0);
        check("rst_sig", sig1, 0);
        check("rst_busy3", busy3, 0);
        check("rst_sig3", sig3, 0);
        rst    = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        step();
        check("idle_no_run", busy1, 0);
        check("idle_no_done", done1, 0);

        // Good DUT.
        run1(0, 0);

        // N22 stuck-at-0.
        run1(1, 0);
        check("sa0_fail_cnt", fail1, 18);
        check("sa0_first_fail", first1, 8);

        // abort is ignored in DONE.
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        check("abort_in_done", done1, 1);
        check("abort_in_done_pass", pass1, 0);

        // Restart from DONE with a good DUT.
        run1(0, 0);

        // Abort at edge 10, with start high on the same edge.
        mode1  = 0;
        start1 = 1'b1;
        step();                        // edge 0
        start1 = 1'b0;
        for (int i = 0; i < 9; i++) step();
        check("abort_pre_tp", tp1, 9);
        abort1 = 1'b1;
        start1 = 1'b1;
        step();                        // edge 10
        abort1 = 1'b0;
        start1 = 1'b0;
        check("abort_busy", busy1, 0);
        check("abort_done", done1, 0);
        check("abort_tp_hold", tp1, 9);
        step();
        check("abort_stay_idle", busy1, 0);
        run1(0, 0);

        // HOLD=3 with a 2-cycle-delayed DUT.
        model(0);
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int p = 0; p < 32; p++) begin
            for (int k = 0; k < 3; k++) begin
                check("h3_tp_hold", tp3, p);
                check("h3_busy", busy3, 1);
                step();
            end
        end
        check("h3_done", done3, 1);
        check("h3_busy_off", busy3, 0);
        check("h3_pass", pass3, 1);
        check("h3_fail_cnt", fail3, 0);
        check("h3_signature", sig3, e_sig);

        // The same delayed DUT fails with HOLD=1.
        run1(3, 0);

        // Random per-pattern corruption with spurious start pulses mid-run.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) begin
                emask[i] = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
            run1(2, 1);
        end

        // start held high: runs restart back-to-back, done pulses one cycle.
        mode1  = 0;
        start1 = 1'b1;
        for (int k = 0; k < 70; k++) begin
            step();
            check("cont_done", done1, (k == 32 || k == 65) ? 1 : 0);
        end
        start1 = 1'b0;
        for (int k = 0; k < 40; k++) step();
        check("cont_final_done", done1, 1);
        check("cont_final_pass", pass1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
